// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin sharing of one interval counter between two requesters
module timer_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] len_q;
    logic             last_q;
    logic             sel_q;
    logic             win;
    logic             granted_req;
    logic             terminal;

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = ~last_q;
        end
    end

    assign granted_req = sel_q ? req1 : req0;
    // len_q of 0 wraps to all-ones, giving a full 2^WIDTH-cycle interval.
    assign terminal    = (count == (len_q - ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            busy   <= 1'b0;
            count  <= '0;
            len_q  <= '0;
            sel_q  <= 1'b0;
            last_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    count <= '0;
                    if (req0 || req1) begin
                        sel_q  <= win;
                        last_q <= win;
                        len_q  <= win ? len1 : len0;
                        gnt0   <= ~win;
                        gnt1   <= win;
                        busy   <= 1'b1;
                        state  <= COUNT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                COUNT: begin
                    // Abort has priority over a same-cycle terminal count.
                    if (!granted_req) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (terminal) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        count <= '0;
                        done0 <= ~sel_q;
                        done1 <= sel_q;
                        state <= DONE;
                    end else begin
                        count <= count + ONE;
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
